// File: rtl/seletor_codigo.sv
// rtl/seletor_codigo.sv - debounced up/down/load code selector with auto-repeat
//
// Produces the registered 5-bit code {A,B,C,D,E} (A = MSB) for the LED decoder.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   btn_up, btn_down, btn_load asynchronous active-high pushbuttons
//   sw[4:0]                    slide switches, loaded on an accepted load press
//   A..E                       registered code, A = bit 4, E = bit 0
//   changed                    one-cycle pulse after the code register changes
module seletor_codigo #(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 8,
  parameter int CODE_MAX     = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [4:0] sw,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       changed
);

  localparam int CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [4:0] CMAX = 5'(CODE_MAX);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  // Button index: 0 = up, 1 = down, 2 = load.
  logic [2:0]         meta_q, sync_q, deb_q, deb_d, deb_prev_q;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [4:0]         sw_meta_q, sw_q;
  logic [4:0]         code_q, code_d;
  logic               changed_q;
  logic [TW-1:0]      timer_q, timer_d;
  logic               dir_q, dir_d;     // 1 = down button owns the repeat
  state_t             state_q, state_d;

  // Debounce: counter runs only while the synchronised level disagrees with
  // the accepted level; the level flips on the DEB_CYCLES-th disagreeing sample.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) deb_d[i] = sync_q[i];
        else                                  cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  logic [2:0] rise;
  logic up_lvl, dn_lvl, up_rise, dn_rise, ld_rise;
  logic start_up, start_dn, held_lvl, opp_lvl, abort, timer_done;
  logic do_step, step_dn;

  assign rise       = deb_q & ~deb_prev_q;
  assign up_lvl     = deb_q[0];
  assign dn_lvl     = deb_q[1];
  assign up_rise    = rise[0];
  assign dn_rise    = rise[1];
  assign ld_rise    = rise[2];
  // A new press only starts a repeat when the opposite button is released.
  assign start_up   = up_rise & ~dn_lvl & ~ld_rise;
  assign start_dn   = dn_rise & ~up_lvl & ~ld_rise;
  assign held_lvl   = dir_q ? dn_lvl : up_lvl;
  assign opp_lvl    = dir_q ? up_lvl : dn_lvl;
  assign abort      = ld_rise | ~held_lvl | opp_lvl;
  assign timer_done = (timer_q == TW'(1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_up || start_dn) state_d = HOLD;
      HOLD, RPT: if (abort)                state_d = IDLE;
                 else if (timer_done)      state_d = RPT;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs (step request, repeat timer, owning direction)
  always_comb begin
    do_step = 1'b0;
    step_dn = dir_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start_up || start_dn) begin
          do_step = 1'b1;
          step_dn = start_dn;
          dir_d   = start_dn;
          timer_d = TW'(REPEAT_DELAY);
        end
      end
      HOLD, RPT: begin
        if (!abort) begin
          if (timer_done) begin
            do_step = 1'b1;
            timer_d = TW'(REPEAT_RATE);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Code datapath: load has priority over stepping.
  always_comb begin
    code_d = code_q;
    if (ld_rise) begin
      code_d = (sw_q > CMAX) ? CMAX : sw_q;
    end else if (do_step) begin
      if (step_dn) code_d = (code_q == 5'd0) ? CMAX  : code_q - 5'd1;
      else         code_d = (code_q == CMAX) ? 5'd0  : code_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      sw_meta_q  <= '0;
      sw_q       <= '0;
      code_q     <= '0;
      changed_q  <= 1'b0;
      timer_q    <= '0;
      dir_q      <= 1'b0;
    end else begin
      meta_q     <= {btn_load, btn_down, btn_up};
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      sw_meta_q  <= sw;
      sw_q       <= sw_meta_q;
      code_q     <= code_d;
      changed_q  <= (code_d != code_q);
      timer_q    <= timer_d;
      dir_q      <= dir_d;
    end
  end

  assign {A, B, C, D, E} = code_q;
  assign changed         = changed_q;

endmodule

// File: tb/tb_seletor_codigo.sv
// tb/tb_seletor_codigo.sv - scoreboard bench for seletor_codigo
module tb_seletor_codigo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       up, dn, ld;
  logic [4:0] sw;
  logic       up2, dn2, ld2;
  logic [4:0] sw2;

  logic [4:0] code_a, code_9, code_20;
  logic       chg_a, chg_9, chg_20;

  seletor_codigo dut_a (
    .clk(clk), .rst_n(rst_n), .btn_up(up), .btn_down(dn), .btn_load(ld), .sw(sw),
    .A(code_a[4]), .B(code_a[3]), .C(code_a[2]), .D(code_a[1]), .E(code_a[0]),
    .changed(chg_a)
  );

  seletor_codigo #(.CODE_MAX(9)) dut_9 (
    .clk(clk), .rst_n(rst_n), .btn_up(up2), .btn_down(dn2), .btn_load(ld2), .sw(sw2),
    .A(code_9[4]), .B(code_9[3]), .C(code_9[2]), .D(code_9[1]), .E(code_9[0]),
    .changed(chg_9)
  );

  seletor_codigo #(.CODE_MAX(20)) dut_20 (
    .clk(clk), .rst_n(rst_n), .btn_up(up2), .btn_down(dn2), .btn_load(ld2), .sw(sw2),
    .A(code_20[4]), .B(code_20[3]), .C(code_20[2]), .D(code_20[1]), .E(code_20[0]),
    .changed(chg_20)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic int m_up(input int c, input int mx);
    return (c == mx) ? 0 : c + 1;
  endfunction
  function automatic int m_dn(input int c, input int mx);
    return (c == 0) ? mx : c - 1;
  endfunction
  function automatic int m_ld(input int s, input int mx);
    return (s > mx) ? mx : s;
  endfunction

  int m_a = 0, m_9 = 0, m_20 = 0;
  int q_a[$], q_9[$], q_20[$];

  // Only a value change produces a changed pulse, so only changes are queued.
  task automatic exp_a(input int v);
    if (v != m_a) q_a.push_back(v);
    m_a = v;
  endtask
  task automatic exp_9(input int v);
    if (v != m_9) q_9.push_back(v);
    m_9 = v;
  endtask
  task automatic exp_20(input int v);
    if (v != m_20) q_20.push_back(v);
    m_20 = v;
  endtask

  always @(negedge clk) begin
    if (chg_a === 1'b1) begin
      if (q_a.size() == 0) check("sb_a_extra", int'(code_a), -1);
      else                 check("sb_a", int'(code_a), q_a.pop_front());
    end
    if (chg_9 === 1'b1) begin
      if (q_9.size() == 0) check("sb_9_extra", int'(code_9), -1);
      else                 check("sb_9", int'(code_9), q_9.pop_front());
    end
    if (chg_20 === 1'b1) begin
      if (q_20.size() == 0) check("sb_20_extra", int'(code_20), -1);
      else                  check("sb_20", int'(code_20), q_20.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic u, input logic d, input logic l);
    up = u; dn = d; ld = l;
  endtask

  // b: 0 = up, 1 = down, 2 = load; 10-cycle press, then idle long enough to release
  task automatic press_a(input int b);
    drive_a(b == 0, b == 1, b == 2);
    tick(10);
    drive_a(1'b0, 1'b0, 1'b0);
    tick(25);
  endtask

  task automatic press_b(input int b);
    up2 = (b == 0); dn2 = (b == 1); ld2 = (b == 2);
    tick(10);
    up2 = 1'b0; dn2 = 1'b0; ld2 = 1'b0;
    tick(25);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0);
    up2 = 1'b0; dn2 = 1'b0; ld2 = 1'b0;
    sw = '0; sw2 = '0;
    tick(3);
    check("rst_code", int'(code_a), 0);
    check("rst_changed", int'(chg_a), 0);
    check("rst_code9", int'(code_9), 0);
    rst_n = 1'b1;

    // Short glitch must be ignored
    drive_a(1'b1, 1'b0, 1'b0);
    tick(3);
    drive_a(1'b0, 1'b0, 1'b0);
    tick(20);
    check("glitch", int'(code_a), 0);

    // Press latency and no repeat after a 10-cycle hold
    exp_a(m_up(m_a, 31));
    drive_a(1'b1, 1'b0, 1'b0);
    tick(6);
    check("lat_edge6", int'(code_a), 0);
    tick(1);
    check("lat_edge7", int'(code_a), 1);
    tick(3);
    drive_a(1'b0, 1'b0, 1'b0);
    tick(40);
    check("no_repeat", int'(code_a), 1);

    // Wrap-around at 31
    sw = 5'd31; tick(3);
    exp_a(m_ld(31, 31)); press_a(2);
    check("load31", int'(code_a), 31);
    exp_a(m_up(m_a, 31)); press_a(0);
    check("wrap_up", int'(code_a), 0);
    exp_a(m_dn(m_a, 31)); press_a(1);
    check("wrap_dn", int'(code_a), 31);

    // Auto-repeat spacing from 0
    sw = 5'd0; tick(3);
    exp_a(m_ld(0, 31)); press_a(2);
    check("load0", int'(code_a), 0);
    for (int k = 0; k < 5; k++) exp_a(m_up(m_a, 31));
    drive_a(1'b1, 1'b0, 1'b0);
    tick(7);  check("rpt_p0", int'(code_a), 1);
    tick(19); check("rpt_p19", int'(code_a), 1);
    tick(1);  check("rpt_p20", int'(code_a), 2);
    tick(8);  check("rpt_p28", int'(code_a), 3);
    tick(8);  check("rpt_p36", int'(code_a), 4);
    tick(8);  check("rpt_p44", int'(code_a), 5);
    drive_a(1'b0, 1'b0, 1'b0);
    tick(20); check("rpt_end", int'(code_a), 5);

    // Load beats a simultaneous up press; reloading the same value is silent
    sw = 5'b10110; tick(3);
    exp_a(m_ld(22, 31));
    drive_a(1'b1, 1'b0, 1'b1);
    tick(10);
    drive_a(1'b0, 1'b0, 1'b0);
    tick(25);
    check("load_up", int'(code_a), 22);
    exp_a(m_ld(22, 31)); press_a(2);
    check("load_same", int'(code_a), 22);

    // Reduced CODE_MAX instances
    sw2 = 5'd9; tick(3);
    exp_9(m_ld(9, 9)); exp_20(m_ld(9, 20)); press_b(2);
    check("c9_load", int'(code_9), 9);
    exp_9(m_up(m_9, 9)); exp_20(m_up(m_20, 20)); press_b(0);
    check("c9_wrap_up", int'(code_9), 0);
    check("c20_up", int'(code_20), 10);
    exp_9(m_dn(m_9, 9)); exp_20(m_dn(m_20, 20)); press_b(1);
    check("c9_wrap_dn", int'(code_9), 9);
    sw2 = 5'd31; tick(3);
    exp_9(m_ld(31, 9)); exp_20(m_ld(31, 20)); press_b(2);
    check("c9_clamp", int'(code_9), 9);
    check("c20_clamp", int'(code_20), 20);

    // Reset in the middle of auto-repeat
    for (int k = 0; k < 3; k++) exp_a(m_up(m_a, 31));
    drive_a(1'b1, 1'b0, 1'b0);
    tick(7);  check("mid_p0", int'(code_a), 23);
    tick(20); check("mid_p20", int'(code_a), 24);
    tick(8);  check("mid_p28", int'(code_a), 25);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_code", int'(code_a), 0);
    check("mid_rst_changed", int'(chg_a), 0);
    check("mid_rst_code20", int'(code_20), 0);
    rst_n = 1'b1;
    m_a = 0; m_9 = 0; m_20 = 0;
    exp_a(m_up(m_a, 31));
    tick(6);  check("post_rst_edge6", int'(code_a), 0);
    tick(1);  check("post_rst_edge7", int'(code_a), 1);
    drive_a(1'b0, 1'b0, 1'b0);
    tick(30); check("post_rst_end", int'(code_a), 1);

    tick(5);
    check("q_a_drained", q_a.size(), 0);
    check("q_9_drained", q_9.size(), 0);
    check("q_20_drained", q_20.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seletor_codigo.md
# seletor_codigo

Sequential front end that generates the 5-bit code consumed by the LED decoder stage (outputs A..E, A = MSB). It debounces three pushbuttons (increment, decrement, load), applies hold-to-auto-repeat stepping with wrap-around, and parallel-loads a code from slide switches. It holds the result in a register so the downstream combinational decoder sees a glitch-free code.

## Interface
- DEB_CYCLES, 4: consecutive stable synchronised samples required to accept a button level change (≥2).
- REPEAT_DELAY, 20: cycles from the first step of a held button to the second step (≥2).
- REPEAT_RATE, 8: cycles between subsequent auto-repeat steps (≥2).
- CODE_MAX, 31: largest legal code (1..31); wrap and clamp limit.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_up  in  1  asynchronous pushbutton, active-high: increment.
- btn_down  in  1  asynchronous pushbutton, active-high: decrement.
- btn_load  in  1  asynchronous pushbutton, active-high: load sw.
- sw  in  5  slide switches, quasi-static; sampled only on an accepted load.
- A, B, C, D, E  out  1 each  registered code, A = bit 4 … E = bit 0.
- changed  out  1  one-cycle pulse on the cycle after the code register changes value.

## Operation
- Each button: 2-flop synchroniser → debouncer (counter increments while synchronised level ≠ debounced level, clears when equal; debounced level flips when DEB_CYCLES consecutive differing samples are seen) → rising-edge detect on the debounced level.
- Step actions (5-bit, mod CODE_MAX+1): up: code = CODE_MAX → 0, else +1. down: code = 0 → CODE_MAX, else −1.
- Load: code ← min(sw, CODE_MAX).
- Priority per cycle: load edge > up/down. Up and down both debounced high → no step, FSM to IDLE.
- Auto-repeat FSM (shared by up/down):
  - IDLE: on accepted up or down edge (other button low) → step once, load timer with REPEAT_DELAY, go HOLD.
  - HOLD: decrement timer. At expiry with same button still debounced high → step, load REPEAT_RATE, go RPT.
  - RPT: step every REPEAT_RATE cycles while held.
  - HOLD/RPT → IDLE, with no step in that cycle, when the held button debounces low, the opposite button debounces high, or a load edge is accepted.
- Load does not auto-repeat; holding load produces exactly one load.
- changed = 1 for exactly one cycle after any cycle where code_next ≠ code. A step or load producing the same value gives no pulse, e.g. load of the current value.

## Timing
- Reset (rst_n low at a rising edge): code = 0 (A..E = 0), changed = 0, synchronisers/debounced levels/edge detectors = 0, counters = 0, FSM = IDLE.
- A button held high across reset release is treated as a new press. It steps DEB_CYCLES+3 edges after release, sampled from the first post-reset edge.
- Press latency: btn first sampled high at edge 1 → code updated at edge DEB_CYCLES+3 (edge 7 with defaults) → changed high during the following cycle.
- A pulse or glitch shorter than DEB_CYCLES synchronised cycles is ignored. Release uses the same debounce latency.
- Auto-repeat spacing is exact: second step REPEAT_DELAY edges after the first, then every REPEAT_RATE edges.
- Reset mid-repeat aborts immediately. No step occurs until a fresh debounced press.
- sw must be stable for ≥2 cycles before the load edge is accepted.
- Outputs change only on rising clk edges; no combinational path from any input to A..E.

## Test plan
- Defaults, reset, hold btn_up 10 cycles → A..E = 00001 at edge 7, changed pulses once, no further step after release.
- btn_up high for 3 cycles, then low → code stays 00000, changed never asserts.
- Code 31: press up → 00000. Then press down → 11111. With CODE_MAX = 9, code 9 + up → 00000 and 0 + down → 01001.
- From 0, hold btn_up so it stays debounced high for 50 cycles after the first step → steps at +0, +20, +28, +36, +44 → final code 00101, no step at +52.
- sw = 10110, btn_load and btn_up pressed together → code 10110 with a single changed pulse. With CODE_MAX = 20 and sw = 11111, load → 10100.
- During RPT, drop rst_n for one edge → A..E = 00000 and changed = 0 next cycle. Button kept held → next step at DEB_CYCLES+3 edges after rst_n release.
